// File: rtl/fb_read_arbiter.sv
// Round-robin arbiter sharing one frame_buffer read port among NUM_REQ readers.
// A grant that is never started is revoked after TIMEOUT cycles.
module fb_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int depth   = 76800,
  parameter int PX_W    = 15,
  parameter int TIMEOUT = 1024,
  localparam int AW = $clog2(depth),
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic                  buffer_clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_rq_read,
  input  logic [NUM_REQ-1:0]    req_reading,
  output logic [NUM_REQ-1:0]    req_ack_read,
  input  logic [NUM_REQ-1:0]    req_read_clk,
  input  logic [NUM_REQ*AW-1:0] req_read_addr,
  output logic                  fb_rq_read,
  output logic                  fb_reading,
  input  logic                  fb_ack_read,
  output logic                  fb_read_clk,
  output logic [AW-1:0]         fb_read_addr,
  input  logic [PX_W-1:0]       fb_px_data,
  output logic [PX_W-1:0]       req_px_data,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  // state        | meaning
  // IDLE         | no owner, arbitrate on any request
  // REQ          | fb_rq_read raised for the winner, waiting for buffer ack
  // GRANT        | ack forwarded to owner, waiting for its reading pulse
  // ACTIVE       | frame read in progress, ack mirrored until buffer drops it
  // RELEASE      | transfer done, waiting for owner to drop its request
  // WAIT_ACK_LOW | aborted request or revoked grant, waiting for ack low
  typedef enum logic [2:0] {IDLE, REQ, GRANT, ACTIVE, RELEASE, WAIT_ACK_LOW} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic            rq_q, rq_d;
  logic            rd_q, rd_d;
  logic            ack_q, ack_d;
  logic            terr_q, terr_d;
  logic [TW-1:0]   timer_q, timer_d;

  // First requester after `last`, wrapping; lowest offset wins.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] rq,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] pick;
    int idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (rq[idx]) pick = GW'(idx);
    end
    return pick;
  endfunction

  always_ff @(posedge buffer_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      rq_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack_q   <= 1'b0;
      terr_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rq_q    <= rq_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rq_d    = rq_q;
    rd_d    = 1'b0;
    ack_d   = ack_q;
    terr_d  = 1'b0;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (|req_rq_read) begin
          grant_d = rr_pick(req_rq_read, last_q);
          rq_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fb_ack_read) begin
          rq_d    = 1'b0;
          ack_d   = 1'b1;
          timer_d = '0;
          state_d = GRANT;
        end else if (!req_rq_read[grant_q]) begin
          rq_d    = 1'b0;
          timer_d = '0;
          state_d = WAIT_ACK_LOW;
        end
      end
      GRANT: begin
        if (req_reading[grant_q]) begin
          rd_d    = 1'b1;
          state_d = ACTIVE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          ack_d   = 1'b0;
          terr_d  = 1'b1;
          last_d  = grant_q;
          timer_d = '0;
          state_d = WAIT_ACK_LOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ACTIVE: begin
        ack_d = fb_ack_read;
        if (!fb_ack_read) begin
          last_d  = grant_q;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!req_rq_read[grant_q]) state_d = IDLE;
      end
      WAIT_ACK_LOW: begin
        // The timer also bounds a buffer that never drops a late ack.
        if (!fb_ack_read || timer_q == TW'(TIMEOUT - 1)) state_d = IDLE;
        else timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fb_read_addr = '0;
    fb_read_clk  = 1'b0;
    if (state_q == GRANT || state_q == ACTIVE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == GW'(i)) begin
          fb_read_addr = req_read_addr[i*AW +: AW];
          fb_read_clk  = req_read_clk[i];
        end
      end
    end
  end

  assign req_ack_read = ack_q ? (NUM_REQ'(1) << grant_q) : '0;
  assign fb_rq_read   = rq_q;
  assign fb_reading   = rd_q;
  assign timeout_err  = terr_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q != IDLE);
  assign req_px_data  = fb_px_data;

endmodule
